cabletest_packet_gen: RTL and testbench
=======================================

Name: cabletest_packet_gen

Overview:
- Packet generator that drives one cable lane of the cable-test design.
- Consumes the start/halt/inject strobes, CYCLES_PER_PACKET and PACKET_COUNT from the cable-test control block.
- Emits fixed-length, pattern-filled AXI-Stream packets toward the transceiver.
- Reports busy / packet-sent / halted status back to the control block.
- Two instances exist: pg_control_1/pg_status_1 and pg_control_2/pg_status_2.

Parameters:
- DATA_WBITS, 512: AXIS tdata width; multiple of 32.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- pg_control  in  3  bit0 start, bit1 halt, bit2 inject; each a 1-cycle strobe.
- pg_status  out  3  bit0 busy (level), bit1 sent (1-cycle pulse), bit2 halted (sticky level).
- cycles_per_packet  in  8  beats per packet; 0 is treated as 1.
- packet_count  in  64  packets to send per run.
- AXIS_TX_TDATA  out  DATA_WBITS  packet data.
- AXIS_TX_TVALID  out  1  data valid.
- AXIS_TX_TLAST  out  1  last beat of a packet.
- AXIS_TX_TREADY  in  1  downstream ready.

Behaviour:
- Reset (resetn=0 at posedge):
  - State goes to IDLE.
  - TVALID=0, TLAST=0, pg_status=0.
  - Pending halt and inject flags cleared.
  - Packet sequence counter = 0.
  - Applies mid-packet as well; a partial packet is abandoned without TLAST.
- States: IDLE, SEND.
- Busy: busy = (state==SEND).
- Start in IDLE:
  - A start with packet_count != 0 latches cpp (0 becomes 1) and remaining = packet_count.
  - Sets packet seq = 0 and beat = 0, and clears halted.
  - Enters SEND; TVALID=1 and busy=1 on the next cycle.
- Start ignored cases: start with packet_count==0 is ignored (no status change); start while in SEND is ignored.
- Beat data: every 32-bit lane k holds {seq[23:0], beat[7:0]}.
- TLAST: TLAST = (beat == cpp-1).
- AXIS rules:
  - While TVALID=1 and TREADY=0, TDATA and TLAST are held stable.
  - TVALID never drops mid-packet except on reset.
- Handshake = TVALID & TREADY.
  - Non-last beat: beat increments.
  - Last beat: sent pulses high for exactly the next cycle, remaining decrements, seq increments, beat returns to 0.
- After a last-beat handshake:
  - If remaining becomes 0, go to IDLE (TVALID=0 next cycle) with halted unchanged (0).
  - Otherwise, if halt is pending, go to IDLE, set halted=1 and clear halt pending.
  - Otherwise, continue straight into the next packet with no idle cycle.
- Halt:
  - Strobe in SEND sets halt pending; the current packet always completes.
  - Strobe in IDLE has no effect.
  - Halt on the same cycle as the final packet's TLAST handshake: normal completion, halted stays 0.
- Inject:
  - Strobe in SEND sets inject pending.
  - The next beat presented with beat==0 has lane 0 bit 0 inverted.
  - If beat 0 of the current packet is already on the bus (not yet handshaken), the corruption applies to the following packet, so held data stays stable.
  - Pending clears on handshake of the corrupted beat.
  - Inject in IDLE is ignored; pending inject is discarded on entering IDLE.
  - One inject strobe corrupts exactly one beat.
- Simultaneous strobes: start+halt in IDLE starts a run with halt pending, so exactly one packet is sent and then halted=1.
- Counter widths: remaining is 64 bits; seq is 32 bits and wraps silently; beat is 8 bits.
- Run length: no upper limit other than packet_count.

Test Plan:
- cpp=4, count=3, TREADY=1, start:
  - Exactly 12 beats, TLAST on beats 3/7/11.
  - Lane-0 data 0x00,01,02,03,0x100..0x103,0x200..0x203.
  - Three sent pulses; busy high from the cycle after start until the cycle after the last handshake.
- Same run with TREADY randomly toggling ~50%: identical beat sequence; TDATA/TLAST unchanged on every stalled cycle; sent count 3.
- cpp=8, count=10, halt strobed during beat 3 of packet 1:
  - Packets 0 and 1 complete, 2 sent pulses, then busy=0 and halted=1.
  - A new start clears halted and restarts with seq 0.
- cpp=4, count=3, inject during packet 0 beat 2:
  - Packet 1 beat 0 lane 0 reads 0x00000101; lane 1 reads 0x00000100.
  - All other beats match the pattern.
- count=0 start, then start during an active run: neither changes status nor output; the active run completes with the original count.
- Reset asserted mid-packet (beat 2 of 4): next cycle TVALID=0, pg_status=0; a subsequent start produces a clean packet from seq 0, beat 0.

Source files
------------

// File: rtl/cabletest_packet_gen_if.sv
// ---------------------------------------------------------------------------
// cabletest_packet_gen_if
//   AXI-Stream transmit channel between one cable-test packet generator and
//   its transceiver lane.
//
//   Signals:
//     AXIS_TX_TDATA   DATA_WBITS  packet data (generator -> transceiver)
//     AXIS_TX_TVALID  1           data valid  (generator -> transceiver)
//     AXIS_TX_TLAST   1           last beat   (generator -> transceiver)
//     AXIS_TX_TREADY  1           ready       (transceiver -> generator)
//
//   Modports:
//     master  packet generator side
//     slave   transceiver side
// ---------------------------------------------------------------------------
interface cabletest_packet_gen_if #(
  parameter int DATA_WBITS = 512
);
  logic [DATA_WBITS-1:0] AXIS_TX_TDATA;
  logic                  AXIS_TX_TVALID;
  logic                  AXIS_TX_TLAST;
  logic                  AXIS_TX_TREADY;

  modport master (
    output AXIS_TX_TDATA,
    output AXIS_TX_TVALID,
    output AXIS_TX_TLAST,
    input  AXIS_TX_TREADY
  );

  modport slave (
    input  AXIS_TX_TDATA,
    input  AXIS_TX_TVALID,
    input  AXIS_TX_TLAST,
    output AXIS_TX_TREADY
  );
endinterface

// File: rtl/cabletest_packet_gen.sv
// ---------------------------------------------------------------------------
// cabletest_packet_gen
//   Drives one cable lane with fixed-length, pattern-filled AXI-Stream
//   packets. A run is started by a start strobe and sends packet_count
//   packets of cycles_per_packet beats each, back to back. A halt strobe
//   stops the run after the packet in flight; an inject strobe flips lane 0
//   bit 0 of one upcoming first beat so the receiver can prove it detects
//   errors.
//
//   Every 32-bit lane of a beat carries {seq[23:0], beat[7:0]}, where seq is
//   the packet number within the run and beat the index inside the packet.
//
//   Ports:
//     clk                in   clock
//     resetn             in   synchronous, active-low reset
//     pg_control[2:0]    in   bit0 start, bit1 halt, bit2 inject (strobes)
//     pg_status[2:0]     out  bit0 busy, bit1 sent (pulse), bit2 halted
//     cycles_per_packet  in   beats per packet, 0 behaves as 1
//     packet_count       in   packets per run, 0 means start is ignored
//     axis_tx            if   AXI-Stream transmit channel (master)
// ---------------------------------------------------------------------------
module cabletest_packet_gen #(
  parameter int DATA_WBITS = 512
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [2:0]                    pg_control,
  output logic [2:0]                    pg_status,
  input  logic [7:0]                    cycles_per_packet,
  input  logic [63:0]                   packet_count,
  cabletest_packet_gen_if.master        axis_tx
);

  localparam int LANES = DATA_WBITS / 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Builds one beat: the lane word replicated across the bus, with lane 0
  // bit 0 flipped when this beat carries an injected error.
  function automatic logic [DATA_WBITS-1:0] build_beat(
    input logic [23:0] seq,
    input logic [7:0]  beat,
    input logic        corrupt
  );
    logic [DATA_WBITS-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      d[32*k +: 32] = {seq, beat};
    end
    d[0] = d[0] ^ corrupt;
    return d;
  endfunction

  state_t                state_r;
  logic [7:0]            cpp_r;
  logic [63:0]           remaining_r;
  logic [31:0]           seq_r;
  logic [7:0]            beat_r;
  logic                  halt_pend_r;
  logic                  inject_pend_r;
  logic                  cur_corrupt_r;   // beat on the bus carries the injected error
  logic                  tvalid_r;
  logic                  tlast_r;
  logic [DATA_WBITS-1:0] tdata_r;
  logic                  sent_r;
  logic                  halted_r;

  logic                  start_s;
  logic                  halt_s;
  logic                  inject_s;
  logic                  hs_s;
  logic                  last_hs_s;
  logic [7:0]            next_beat_s;
  logic [31:0]           next_seq_s;
  logic                  corrupt_next_s;
  logic [7:0]            cpp_start_s;

  // Decodes strobes and precomputes the beat that follows the current one.
  always_comb begin
    start_s        = pg_control[0];
    halt_s         = pg_control[1];
    inject_s       = pg_control[2];
    hs_s           = tvalid_r & axis_tx.AXIS_TX_TREADY;
    last_hs_s      = hs_s & tlast_r;
    next_beat_s    = 8'd0;
    next_seq_s     = seq_r;
    corrupt_next_s = 1'b0;
    cpp_start_s    = cycles_per_packet;

    if (last_hs_s) begin
      next_beat_s = 8'd0;
      next_seq_s  = seq_r + 32'd1;
    end else begin
      next_beat_s = beat_r + 8'd1;
      next_seq_s  = seq_r;
    end

    // A pending inject that is already riding on the current beat must not
    // be applied a second time; a strobe arriving now still counts.
    if (next_beat_s == 8'd0) begin
      corrupt_next_s = (inject_pend_r & ~cur_corrupt_r) | inject_s;
    end else begin
      corrupt_next_s = 1'b0;
    end

    if (cycles_per_packet == 8'd0) begin
      cpp_start_s = 8'd1;
    end else begin
      cpp_start_s = cycles_per_packet;
    end
  end

  // Run control FSM with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= IDLE;
      cpp_r         <= 8'd1;
      remaining_r   <= 64'd0;
      seq_r         <= 32'd0;
      beat_r        <= 8'd0;
      halt_pend_r   <= 1'b0;
      inject_pend_r <= 1'b0;
      cur_corrupt_r <= 1'b0;
      tvalid_r      <= 1'b0;
      tlast_r       <= 1'b0;
      tdata_r       <= '0;
      sent_r        <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      sent_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s && (packet_count != 64'd0)) begin
            cpp_r         <= cpp_start_s;
            remaining_r   <= packet_count;
            seq_r         <= 32'd0;
            beat_r        <= 8'd0;
            halted_r      <= 1'b0;
            halt_pend_r   <= halt_s;   // start+halt sends exactly one packet
            inject_pend_r <= 1'b0;
            cur_corrupt_r <= 1'b0;
            tvalid_r      <= 1'b1;
            tlast_r       <= (cpp_start_s == 8'd1);
            tdata_r       <= build_beat(24'd0, 8'd0, 1'b0);
            state_r       <= SEND;
          end
        end

        SEND: begin
          if (halt_s) begin
            halt_pend_r <= 1'b1;
          end
          if (inject_s) begin
            inject_pend_r <= 1'b1;
          end else if (hs_s && cur_corrupt_r) begin
            inject_pend_r <= 1'b0;
          end

          if (hs_s) begin
            // Load the following beat; overridden below when the run ends.
            beat_r        <= next_beat_s;
            seq_r         <= next_seq_s;
            tdata_r       <= build_beat(next_seq_s[23:0], next_beat_s, corrupt_next_s);
            tlast_r       <= (next_beat_s == (cpp_r - 8'd1));
            cur_corrupt_r <= corrupt_next_s;

            if (tlast_r) begin
              sent_r      <= 1'b1;
              remaining_r <= remaining_r - 64'd1;
              // Final packet wins over a coincident halt: no halted flag.
              if ((remaining_r == 64'd1) || halt_pend_r || halt_s) begin
                state_r       <= IDLE;
                tvalid_r      <= 1'b0;
                tlast_r       <= 1'b0;
                halt_pend_r   <= 1'b0;
                inject_pend_r <= 1'b0;
                cur_corrupt_r <= 1'b0;
                halted_r      <= (remaining_r != 64'd1);
              end
            end
          end
        end

        default: begin
          state_r  <= IDLE;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pg_status              = {halted_r, sent_r, (state_r == SEND)};
  assign axis_tx.AXIS_TX_TDATA  = tdata_r;
  assign axis_tx.AXIS_TX_TVALID = tvalid_r;
  assign axis_tx.AXIS_TX_TLAST  = tlast_r;

endmodule

// File: tb/tb_cabletest_packet_gen.sv
// ---------------------------------------------------------------------------
// tb_cabletest_packet_gen
//   Self-checking bench for cabletest_packet_gen. Runs are described by a
//   table of records (directed cases with fixed expected results, plus
//   randomized cases). Every cycle of a run is checked against a packet-level
//   model: the expected beat is (packet, beat) with the lane pattern derived
//   arithmetically, the run length shrinks on halt, and an inject marks the
//   first beat of the next packet.
// ---------------------------------------------------------------------------
module tb_cabletest_packet_gen;

  localparam int DW    = 512;
  localparam int LANES = DW / 32;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  pg_control;
  logic [2:0]  pg_status;
  logic [7:0]  cycles_per_packet;
  logic [63:0] packet_count;

  cabletest_packet_gen_if #(.DATA_WBITS(DW)) axis_tx();

  cabletest_packet_gen #(.DATA_WBITS(DW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .pg_control        (pg_control),
    .pg_status         (pg_status),
    .cycles_per_packet (cycles_per_packet),
    .packet_count      (packet_count),
    .axis_tx           (axis_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cpp;
    int cnt;
    int rdy;          // percent chance of TREADY per cycle
    int halt_cyc;     // -1 none, 0 together with start
    int inj_cyc;      // -1 none
    int restart_cyc;  // -1 none; start strobe while running
    int exp_pkts;     // -1: random case, no fixed expectation
    int exp_halted;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  bit   halted_e = 1'b0;
  vec_t tbl[16];

  function automatic vec_t mk(int cpp, int cnt, int rdy, int hc, int ic, int rc, int ep, int eh);
    vec_t v;
    v.cpp = cpp; v.cnt = cnt; v.rdy = rdy; v.halt_cyc = hc;
    v.inj_cyc = ic; v.restart_cyc = rc; v.exp_pkts = ep; v.exp_halted = eh;
    return v;
  endfunction

  function automatic logic [DW-1:0] pattern(int pkt, int beat, bit corrupt);
    logic [DW-1:0] d;
    logic [31:0]   w;
    w = 32'(pkt) * 32'd256 + 32'(beat);
    for (int k = 0; k < LANES; k++) d[32*k +: 32] = w;
    if (corrupt) d[0] = ~d[0];
    return d;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input vec_t v);
    int cpp_e, pkt, beat, total, corrupt_pkt, sent_seen;
    bit busy_e, sent_e, halt_seen, ready, done;
    cpp_e = (v.cpp == 0) ? 1 : v.cpp;
    cycles_per_packet = 8'(v.cpp);
    packet_count      = 64'(v.cnt);
    axis_tx.AXIS_TX_TREADY = 1'b0;
    pg_control = 3'b001;
    if (v.halt_cyc == 0) pg_control[1] = 1'b1;
    tick();
    pg_control = 3'b000;

    busy_e = 1'b1; sent_e = 1'b0; halted_e = 1'b0;
    pkt = 0; beat = 0; total = v.cnt; corrupt_pkt = -1; sent_seen = 0;
    halt_seen = (v.halt_cyc == 0);
    if (halt_seen && total > 1) total = 1;
    done = 1'b0;

    for (int cyc = 1; cyc < 3000 && !done; cyc++) begin
      check1("busy", pg_status[0], busy_e);
      check1("sent", pg_status[1], sent_e);
      check1("halted", pg_status[2], halted_e);
      check1("tvalid", axis_tx.AXIS_TX_TVALID, busy_e);
      if (pg_status[1]) sent_seen++;
      if (!busy_e) begin
        done = 1'b1;
      end else begin
        checkw("tdata", axis_tx.AXIS_TX_TDATA, pattern(pkt, beat, (pkt == corrupt_pkt) && (beat == 0)));
        check1("tlast", axis_tx.AXIS_TX_TLAST, beat == cpp_e - 1);
        ready = ($urandom_range(99, 0) < v.rdy);
        axis_tx.AXIS_TX_TREADY = ready;
        if (cyc == v.halt_cyc) begin
          pg_control[1] = 1'b1;
          if (!halt_seen) begin
            halt_seen = 1'b1;
            if (pkt + 1 < total) total = pkt + 1;
          end
        end
        if (cyc == v.inj_cyc) begin
          pg_control[2] = 1'b1;
          corrupt_pkt = pkt + 1;
        end
        if (cyc == v.restart_cyc) begin
          pg_control[0] = 1'b1;
          packet_count  = 64'(v.cnt + 5);
        end
        tick();
        pg_control = 3'b000;
        sent_e = 1'b0;
        if (ready) begin
          if (beat == cpp_e - 1) begin
            sent_e = 1'b1;
            beat = 0;
            pkt++;
            if (pkt == total) begin
              busy_e   = 1'b0;
              halted_e = halt_seen && (total < v.cnt);
            end
          end else begin
            beat++;
          end
        end
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: run still busy after 3000 cycles, expected idle");
    end
    checki("sent_count", sent_seen, total);
    if (v.exp_pkts >= 0) begin
      checki("pkts_tbl", sent_seen, v.exp_pkts);
      check1("halted_tbl", pg_status[2], v.exp_halted != 0);
    end
    axis_tx.AXIS_TX_TREADY = 1'b0;
    tick();
    check1("sent_drop", pg_status[1], 1'b0);
    check1("idle_tvalid", axis_tx.AXIS_TX_TVALID, 1'b0);
  endtask

  initial begin
    // Directed runs from the test plan, then randomized runs.
    tbl[0] = mk(4, 3, 100, -1, -1, -1, 3, 0);
    tbl[1] = mk(4, 3, 50,  -1, -1, -1, 3, 0);
    tbl[2] = mk(8, 10, 100, 12, -1, -1, 2, 1);   // halt during packet 1 beat 3
    tbl[3] = mk(4, 3, 100, -1, 3,  -1, 3, 0);    // inject during packet 0 beat 2
    tbl[4] = mk(4, 3, 100, -1, -1, 5,  3, 0);    // start while running ignored
    tbl[5] = mk(0, 2, 100, -1, -1, -1, 2, 0);    // cpp 0 behaves as 1
    tbl[6] = mk(1, 3, 100, 0,  -1, -1, 1, 1);    // start+halt together
    tbl[7] = mk(3, 2, 100, 6,  -1, -1, 2, 0);    // halt on final TLAST handshake
    for (int i = 8; i < 16; i++) begin
      tbl[i] = mk(int'($urandom_range(5, 0)), int'($urandom_range(4, 1)),
                  int'($urandom_range(100, 30)),
                  ($urandom_range(1, 0) != 0) ? int'($urandom_range(30, 1)) : -1,
                  ($urandom_range(1, 0) != 0) ? int'($urandom_range(20, 1)) : -1,
                  ($urandom_range(1, 0) != 0) ? int'($urandom_range(20, 1)) : -1,
                  -1, 0);
    end

    resetn = 1'b0;
    pg_control = 3'b000;
    cycles_per_packet = 8'd0;
    packet_count = 64'd0;
    axis_tx.AXIS_TX_TREADY = 1'b0;
    repeat (3) tick();
    checki("reset_status", int'(pg_status), 0);
    check1("reset_tvalid", axis_tx.AXIS_TX_TVALID, 1'b0);
    check1("reset_tlast", axis_tx.AXIS_TX_TLAST, 1'b0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) run_case(tbl[i]);

    // Leave halted set, then check zero-count start and idle strobes.
    run_case(mk(2, 5, 100, 2, -1, -1, 1, 1));
    packet_count = 64'd0;
    cycles_per_packet = 8'd4;
    pg_control = 3'b001;
    tick();
    pg_control = 3'b000;
    checki("zero_count_status", int'(pg_status), 4);
    check1("zero_count_tvalid", axis_tx.AXIS_TX_TVALID, 1'b0);
    pg_control = 3'b110;
    tick();
    pg_control = 3'b000;
    tick();
    checki("idle_strobe_status", int'(pg_status), 4);
    check1("idle_strobe_tvalid", axis_tx.AXIS_TX_TVALID, 1'b0);
    run_case(mk(4, 2, 100, -1, -1, -1, 2, 0));

    // Reset in the middle of a packet.
    cycles_per_packet = 8'd4;
    packet_count = 64'd3;
    axis_tx.AXIS_TX_TREADY = 1'b1;
    pg_control = 3'b001;
    tick();
    pg_control = 3'b000;
    tick();
    tick();
    checkw("pre_reset_beat2", axis_tx.AXIS_TX_TDATA, pattern(0, 2, 1'b0));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checki("midreset_status", int'(pg_status), 0);
    check1("midreset_tvalid", axis_tx.AXIS_TX_TVALID, 1'b0);
    check1("midreset_tlast", axis_tx.AXIS_TX_TLAST, 1'b0);
    axis_tx.AXIS_TX_TREADY = 1'b0;
    tick();
    check1("post_reset_idle", axis_tx.AXIS_TX_TVALID, 1'b0);
    halted_e = 1'b0;
    run_case(mk(4, 1, 100, -1, -1, -1, 1, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
